// File: rtl/adc_sweep_ctrl_if.sv
// Command/status and RAM port B bundle between the host side and adc_sweep_ctrl.
// The master drives commands; the slave (the sequencer) drives capture-stage control, port B and status.
`timescale 1ns/1ps
interface adc_sweep_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int PASS_W = 16
);
  logic              cmd_start;
  logic              cmd_abort;
  logic [PASS_W-1:0] cmd_passes;
  logic [5:0]        cfg_odd;
  logic [5:0]        cfg_even;
  logic [ADDR_W-1:0] host_rd_addr;

  logic              adc_start;
  logic [31:0]       adc_config_odd;
  logic [31:0]       adc_config_even;
  logic [ADDR_W-1:0] ram_b_addr;
  logic              ram_b_we;
  logic [31:0]       ram_b_wr_data;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_count;

  modport master (
    output cmd_start, cmd_abort, cmd_passes, cfg_odd, cfg_even, host_rd_addr,
    input  adc_start, adc_config_odd, adc_config_even, ram_b_addr, ram_b_we,
           ram_b_wr_data, busy, done, pass_count
  );

  modport slave (
    input  cmd_start, cmd_abort, cmd_passes, cfg_odd, cfg_even, host_rd_addr,
    output adc_start, adc_config_odd, adc_config_even, ram_b_addr, ram_b_we,
           ram_b_wr_data, busy, done, pass_count
  );
endinterface

// File: rtl/adc_sweep_ctrl.sv
// Sweep sequencer for the ADC capture/accumulate stage: clears the accumulation RAM via port B,
// releases the capture stage for N full sweeps, then freezes it and hands port B to host readout.
`timescale 1ns/1ps
module adc_sweep_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int SAMPLE_CYC = 321,
  parameter int PASS_W     = 16
) (
  input logic              clk,
  input logic              reset,
  adc_sweep_ctrl_if.slave  bus
);

  localparam int SAMP_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLE_CYC - 1);
  localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  logic [PASS_W-1:0]   r_passes;
  logic [5:0]          r_cfg_odd;
  logic [5:0]          r_cfg_even;
  logic [SAMP_W-1:0]   r_samp_cnt;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic                r_adc_start;
  logic                r_busy;
  logic                r_done;
  logic [PASS_W-1:0]   r_pass_count;

  logic                w_samp_wrap;
  logic                w_addr_wrap;
  logic [PASS_W-1:0]   w_pass_next;
  logic                w_run_end;

  assign w_samp_wrap = (r_samp_cnt == SAMP_LAST);
  assign w_addr_wrap = w_samp_wrap && (r_addr_cnt == ADDR_LAST);
  assign w_pass_next = r_pass_count + PASS_ONE;
  // The run ends on the very edge the final sweep wraps, so the last sample period is complete.
  assign w_run_end   = w_addr_wrap && (w_pass_next == r_passes);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_passes     <= '0;
      r_cfg_odd    <= '0;
      r_cfg_even   <= '0;
      r_samp_cnt   <= '0;
      r_addr_cnt   <= '0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_adc_start  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.cmd_abort) begin
        r_state     <= S_IDLE;
        r_adc_start <= 1'b1;
        r_ram_we    <= 1'b0;
        r_busy      <= 1'b0;
        r_ram_addr  <= bus.host_rd_addr;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ram_addr <= bus.host_rd_addr;
            if (bus.cmd_start) begin
              r_state      <= S_CLEAR;
              r_passes     <= bus.cmd_passes;
              r_cfg_odd    <= bus.cfg_odd;
              r_cfg_even   <= bus.cfg_even;
              r_pass_count <= '0;
              r_ram_addr   <= '0;
              r_ram_we     <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
          S_CLEAR: begin
            if (r_ram_addr == ADDR_LAST) begin
              r_ram_we <= 1'b0;
              if (r_passes == '0) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_ram_addr <= bus.host_rd_addr;
              end else begin
                r_state     <= S_RUN;
                r_adc_start <= 1'b0;
                r_samp_cnt  <= '0;
                r_addr_cnt  <= '0;
              end
            end else begin
              r_ram_addr <= r_ram_addr + ADDR_ONE;
            end
          end
          S_RUN: begin
            r_samp_cnt <= w_samp_wrap ? '0 : (r_samp_cnt + SAMP_ONE);
            if (w_samp_wrap) r_addr_cnt <= r_addr_cnt + ADDR_ONE;
            if (w_addr_wrap) r_pass_count <= w_pass_next;
            if (w_run_end) begin
              r_state     <= S_IDLE;
              r_adc_start <= 1'b1;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_ram_addr  <= bus.host_rd_addr;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.adc_start       = r_adc_start;
  assign bus.adc_config_odd  = {26'd0, r_cfg_odd};
  assign bus.adc_config_even = {26'd0, r_cfg_even};
  assign bus.ram_b_addr      = r_ram_addr;
  assign bus.ram_b_we        = r_ram_we;
  assign bus.ram_b_wr_data   = 32'd0;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass_count      = r_pass_count;

endmodule

// File: tb/tb_adc_sweep_ctrl.sv
// Bench for adc_sweep_ctrl with a small accumulation RAM and capture-stage model attached.
// A phase-based timeline model is compared against the DUT every cycle; directed runs add literal checks.
`timescale 1ns/1ps
module tb_adc_sweep_ctrl;

  localparam int AW    = 4;
  localparam int SC    = 8;
  localparam int PW    = 16;
  localparam int NCLR  = 1 << AW;
  localparam int SWEEP = NCLR * SC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adc_sweep_ctrl_if #(.ADDR_W(AW), .PASS_W(PW)) bus ();

  adc_sweep_ctrl #(.ADDR_W(AW), .SAMPLE_CYC(SC), .PASS_W(PW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accumulation RAM: port B from the DUT, port A from a capture stage adding 5 per sample.
  logic [31:0] ram [NCLR];
  int          cap_cnt;
  logic [AW-1:0] cap_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCLR; i++) ram[i] <= 32'hBAD0_0000 + 32'(i);
      cap_cnt  <= 0;
      cap_addr <= '0;
    end else begin
      if (bus.ram_b_we) ram[bus.ram_b_addr] <= bus.ram_b_wr_data;
      if (bus.adc_start) begin
        cap_cnt  <= 0;
        cap_addr <= '0;
      end else begin
        cap_cnt <= (cap_cnt == SC - 1) ? 0 : cap_cnt + 1;
        if (cap_cnt == SC - 4) begin
          ram[cap_addr] <= ram[cap_addr] + 32'd5;
          cap_addr      <= cap_addr + 4'd1;
        end
      end
    end
  end

  // Timeline model: m_ph counts edges since the accepted start; clear occupies phases 0..NCLR-1,
  // the run occupies the next n*SWEEP phases, and completed sweeps follow by division.
  bit          m_busy, m_done;
  int          m_ph, m_n, m_pc;
  logic [5:0]  m_odd, m_even;
  logic [AW-1:0] m_baddr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_ph <= 0; m_n <= 0; m_pc <= 0;
      m_odd <= '0; m_even <= '0; m_baddr <= '0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        m_baddr <= bus.host_rd_addr;
        if (bus.cmd_start && !bus.cmd_abort) begin
          m_busy <= 1; m_ph <= 0; m_n <= int'(bus.cmd_passes); m_pc <= 0;
          m_odd <= bus.cfg_odd; m_even <= bus.cfg_even; m_baddr <= '0;
        end
      end else if (bus.cmd_abort) begin
        m_busy <= 0; m_baddr <= bus.host_rd_addr;
      end else if (m_ph + 1 == NCLR + m_n * SWEEP) begin
        m_busy <= 0; m_done <= 1; m_pc <= m_n; m_baddr <= bus.host_rd_addr;
      end else begin
        m_ph <= m_ph + 1;
        if (m_ph + 1 < NCLR) m_baddr <= AW'(m_ph + 1);
        else m_pc <= (m_ph + 1 - NCLR) / SWEEP;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("adc_start", bus.adc_start, !(m_busy && m_ph >= NCLR));
      check("ram_b_we", bus.ram_b_we, m_busy && m_ph < NCLR);
      check("ram_b_wr_data", bus.ram_b_wr_data, 0);
      check("pass_count", bus.pass_count, m_pc);
      check("adc_config_odd", bus.adc_config_odd, {26'd0, m_odd});
      check("adc_config_even", bus.adc_config_even, {26'd0, m_even});
      if (!(m_busy && m_ph >= NCLR)) check("ram_b_addr", bus.ram_b_addr, m_baddr);
    end
  end

  task automatic run_job(input int n, input logic [5:0] odd, input logic [5:0] even,
                         input bit restart, input int abort_at,
                         output int t_done, output int n_we, output int n_low,
                         output int pc_done, output bit saw_done);
    t_done = 0; n_we = 0; n_low = 0; pc_done = -1; saw_done = 0;
    @(negedge clk);
    bus.cmd_passes = PW'(n); bus.cfg_odd = odd; bus.cfg_even = even; bus.cmd_start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 20000; k++) begin
      if (k > 1) @(negedge clk);
      bus.cmd_start = 1'b0;
      if (bus.ram_b_we) n_we++;
      if (!bus.adc_start) n_low++;
      if (bus.done) begin
        saw_done = 1; t_done = k; pc_done = int'(bus.pass_count);
        break;
      end
      if (restart && k == 5) bus.cmd_start = 1'b1;
      if (abort_at > 0 && n_low == abort_at) begin
        bus.cmd_abort = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    @(negedge clk);
    bus.host_rd_addr = AW'(a);
    @(negedge clk);
    check("host_rd_latency", bus.ram_b_addr, a);
    d = ram[bus.ram_b_addr];
  endtask

  initial begin
    int t_done, n_we, n_low, pc_done;
    bit saw_done;
    logic [31:0] d;

    bus.cmd_start = 0; bus.cmd_abort = 0; bus.cmd_passes = '0;
    bus.cfg_odd = '0; bus.cfg_even = '0; bus.host_rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_adc_start", bus.adc_start, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ram_b_we", bus.ram_b_we, 0);
    check("rst_ram_b_addr", bus.ram_b_addr, 0);
    check("rst_pass_count", bus.pass_count, 0);
    check("rst_cfg_odd", bus.adc_config_odd, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    read_word(9, d);
    check("idle_read_garbage", d, 32'hBAD0_0009);

    // Clear-only run
    run_job(0, 6'h01, 6'h02, 0, 0, t_done, n_we, n_low, pc_done, saw_done);
    check("p0_done_seen", saw_done, 1);
    check("p0_done_time", t_done, 17);
    check("p0_we_cycles", n_we, 16);
    check("p0_adc_low", n_low, 0);
    check("p0_pass_count", pc_done, 0);
    for (int a = 0; a < NCLR; a++) begin
      read_word(a, d);
      check("p0_ram_zero", d, 0);
    end

    // Three passes with config latch
    run_job(3, 6'h2A, 6'h15, 0, 0, t_done, n_we, n_low, pc_done, saw_done);
    check("p3_done_seen", saw_done, 1);
    check("p3_done_time", t_done, 401);
    check("p3_adc_low", n_low, 384);
    check("p3_we_cycles", n_we, 16);
    check("p3_pass_count", pc_done, 3);
    check("p3_cfg_odd", bus.adc_config_odd, 32'h2A);
    check("p3_cfg_even", bus.adc_config_even, 32'h15);

    // Second start during clear is ignored
    run_job(3, 6'h2A, 6'h15, 1, 0, t_done, n_we, n_low, pc_done, saw_done);
    check("rs_done_time", t_done, 401);
    check("rs_adc_low", n_low, 384);

    // Four passes of constant sample 5 accumulate to 20 everywhere
    run_job(4, 6'h03, 6'h04, 0, 0, t_done, n_we, n_low, pc_done, saw_done);
    check("p4_done_time", t_done, 17 + 4 * SWEEP);
    check("p4_pass_count", pc_done, 4);
    for (int a = 0; a < NCLR; a++) begin
      read_word(a, d);
      check("p4_ram_sum", d, 20);
    end

    // Abort after 800 run cycles: 799 run edges processed -> 6 full sweeps
    run_job(10, 6'h05, 6'h06, 0, 800, t_done, n_we, n_low, pc_done, saw_done);
    check("ab_no_done_before", saw_done, 0);
    @(negedge clk);
    bus.cmd_abort = 1'b0;
    check("ab_adc_start", bus.adc_start, 1);
    check("ab_busy", bus.busy, 0);
    check("ab_done", bus.done, 0);
    check("ab_pass_count", bus.pass_count, 6);
    repeat (4) begin
      @(negedge clk);
      check("ab_no_done_after", bus.done, 0);
    end

    // Start and abort together in idle: abort wins
    @(negedge clk);
    bus.cmd_start = 1'b1; bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0;
    check("sa_busy", bus.busy, 0);
    check("sa_we", bus.ram_b_we, 0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    bus.cmd_passes = PW'(5); bus.cfg_odd = 6'h3F; bus.cfg_even = 6'h3F; bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    repeat (299) @(negedge clk);
    check("mr_pre_adc_start", bus.adc_start, 0);
    check("mr_pre_pass_count", bus.pass_count, 2);
    #2 rst = 1'b1;
    #1;
    check("mr_adc_start", bus.adc_start, 1);
    check("mr_busy", bus.busy, 0);
    check("mr_we", bus.ram_b_we, 0);
    check("mr_addr", bus.ram_b_addr, 0);
    check("mr_pass_count", bus.pass_count, 0);
    check("mr_cfg_odd", bus.adc_config_odd, 0);
    check("mr_cfg_even", bus.adc_config_even, 0);
    check("mr_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
